// File: rtl/mem_io_responder_pkg.sv
// mem_io_pkg: address map, region decode and shared types for the memory/I/O responder.
package mem_io_pkg;
  localparam logic [17:0] IO_PORT_ADDR = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
  localparam logic [17:0] RAM_TOP      = 18'h20000;
  typedef enum logic [1:0] {RG_RAM, RG_HOLE, RG_IO} region_e;
  function automatic region_e decode(input logic [17:0] a);
    return (a < RAM_TOP) ? RG_RAM : a[16] ? RG_IO : RG_HOLE;
  endfunction
endpackage

// File: rtl/mem_io_responder_fifo.sv
// tx_byte_fifo: UART TX byte queue with drop-on-full and a registered almost-full flag.
module tx_byte_fifo #(
  parameter int AW = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       empty_o,
  output logic       almost_full_o,
  output logic       overflow_o
);
  localparam int DEPTH = 2 ** AW;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, do_push, do_pop, af_q;
  assign full     = cnt_q == (AW+1)'(DEPTH);
  assign empty_o  = cnt_q == '0;
  assign do_pop   = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a push into a full queue needs.
  assign do_push  = push_i && (!full || do_pop);
  assign overflow_o    = push_i && !do_push;
  assign data_o        = mem_q[rd_q];
  assign almost_full_o = af_q;
  always_comb cnt_d = (do_push && !do_pop) ? cnt_q + (AW+1)'(1) :
                      (!do_push && do_pop) ? cnt_q - (AW+1)'(1) : cnt_q;
  always_ff @(posedge clk_i) if (do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      af_q  <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      af_q  <= cnt_d >= (AW+1)'(DEPTH - 1);
    end
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU byte-bus responder with 128KB RAM,
// a free-running cycle counter with byte snapshot, and sticky program-stop/overflow flags.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int    ADDR_WIDTH = 17,
  parameter int    FIFO_AW    = 3,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rx_pop,
  output logic        program_finished,
  output logic        tx_overflow
);
  logic [7:0]  ram [2**ADDR_WIDTH];
  logic [7:0]  din_q, rd_d, io_d, push_data;
  logic [31:0] cnt_q, snap_q;
  logic        fin_q, ovf_q, tx_empty, fifo_ovf, push;
  region_e     rg;
  logic [2:0]  off;
  logic        io_rd, io_wr, at_port, at_clk;
  logic        unused_hi;
  assign unused_hi = ^mem_a[31:18];
  assign rg      = decode(mem_a[17:0]);
  assign off     = mem_a[2:0];
  assign io_rd   = !mem_wr && rg == RG_IO;
  assign io_wr   = mem_wr && rg == RG_IO;
  assign at_port = off == IO_PORT_ADDR[2:0];
  assign at_clk  = off == IO_CLK_ADDR[2:0];
  assign push      = io_wr && ((at_port && mem_dout != 8'h00) || at_clk);
  assign push_data = at_clk ? 8'h00 : mem_dout;
  assign uart_rx_pop = io_rd && at_port && uart_rx_valid;
  always_comb begin
    io_d = (at_port && uart_rx_valid) ? uart_rx_data :
           at_clk                     ? cnt_q[7:0]   :
           off == 3'd5                ? snap_q[15:8] :
           off == 3'd6                ? snap_q[23:16] :
           off == 3'd7                ? snap_q[31:24] : 8'h00;
    rd_d = rg == RG_RAM ? ram[mem_a[ADDR_WIDTH-1:0]] : rg == RG_IO ? io_d : 8'h00;
  end
  always_ff @(posedge clk_in) if (mem_wr && rg == RG_RAM) ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      din_q  <= 8'h00;
      cnt_q  <= '0;
      snap_q <= '0;
      fin_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
      if (!mem_wr) din_q <= rd_d;
      if (io_rd && at_clk) snap_q <= cnt_q;
      if (io_wr && at_clk) fin_q <= 1'b1;
      if (fifo_ovf) ovf_q <= 1'b1;
    end
  tx_byte_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk_i         (clk_in),
    .rst_ni        (rst_in_n),
    .push_i        (push),
    .data_i        (push_data),
    .pop_i         (uart_tx_ready),
    .data_o        (uart_tx_data),
    .empty_o       (tx_empty),
    .almost_full_o (io_buffer_full),
    .overflow_o    (fifo_ovf)
  );
  assign uart_tx_valid    = !tx_empty;
  assign mem_din          = din_q;
  assign program_finished = fin_q;
  assign tx_overflow      = ovf_q;
endmodule
